// File: rtl/tetris_drop_ctrl.sv
// tetris_drop_ctrl
//   Game-play sequencer for a 20x10 playfield with a falling 2x2 piece.
//   Owns the settled-block occupancy map, the falling piece position,
//   gravity timing, player moves, locking, line clears and respawn.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   start                    begins a game from IDLE or GAMEOVER
//   move_left, move_right    single-cycle move requests (FALL only)
//   soft_drop                forces an immediate gravity step (FALL only)
//   piece_row, piece_col     top-left cell of the falling piece
//   piece_valid              high while a piece is falling
//   stack_map                settled cells, bit = row*10+col, row 0 on top
//   lines                    lines cleared this game, saturating
//   busy                     high in SPAWN, LOCK, CLEAR
//   game_over                high in GAMEOVER
//
// State     | meaning
// IDLE      | after reset, waiting for start
// SPAWN     | place new piece at (0,4), detect top-out
// FALL      | piece under player/gravity control
// LOCK      | merge piece into stack_map
// CLEAR     | two row checks starting at the piece's lower row
// GAMEOVER  | map and lines frozen until start
module tetris_drop_ctrl #(
  parameter int DROP_DIV = 25000000,
  parameter int LINES_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               soft_drop,
  output logic [4:0]         piece_row,
  output logic [3:0]         piece_col,
  output logic               piece_valid,
  output logic [199:0]       stack_map,
  output logic [LINES_W-1:0] lines,
  output logic               busy,
  output logic               game_over
);

  localparam int GW = $clog2(DROP_DIV);
  localparam logic [GW-1:0] GRAV_TOP = GW'(DROP_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_FALL, S_LOCK, S_CLEAR, S_GAMEOVER
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           row_q, row_d;
  logic [3:0]           col_q, col_d;
  logic [199:0]         map_q, map_d;
  logic [LINES_W-1:0]   lines_q, lines_d;
  logic [GW-1:0]        grav_q, grav_d;
  logic [4:0]           chk_q, chk_d;
  logic [1:0]           rem_q, rem_d;

  logic                 mv;
  logic                 grav_evt;
  logic [7:0]           base;
  logic [7:0]           keep_sh;
  logic [199:0]         keep_mask;

  // Off-board cells read as occupied so edge checks need no special case.
  function automatic logic occupied(input logic [199:0] m,
                                    input logic [4:0]   r,
                                    input logic [3:0]   c);
    logic [7:0] idx;
    idx = 8'(r) * 8'd10 + 8'(c);
    occupied = (r > 5'd19 || c > 4'd9) ? 1'b1 : m[idx];
  endfunction

  function automatic logic row_full(input logic [199:0] m,
                                    input logic [4:0]   r);
    logic [7:0] idx;
    idx = 8'(r) * 8'd10;
    row_full = &m[idx +: 10];
  endfunction

  assign mv   = move_left | move_right;
  assign base = 8'(row_q) * 8'd10 + 8'(col_q);

  // Rows below chk keep their contents; rows 0..chk take the row above,
  // which a plain 10-bit left shift of the whole map provides.
  assign keep_sh   = (8'(chk_q) + 8'd1) * 8'd10;
  assign keep_mask = {200{1'b1}} << keep_sh;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    map_d    = map_q;
    lines_d  = lines_q;
    grav_d   = grav_q;
    chk_d    = chk_q;
    rem_d    = rem_q;
    grav_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        row_d  = '0;
        col_d  = 4'd4;
        grav_d = '0;
        if (occupied(map_q, 5'd0, 4'd4) || occupied(map_q, 5'd0, 4'd5) ||
            occupied(map_q, 5'd1, 4'd4) || occupied(map_q, 5'd1, 4'd5))
          state_d = S_GAMEOVER;
        else
          state_d = S_FALL;
      end
      S_FALL: begin
        if (move_left && !move_right) begin
          if (col_q != 4'd0 &&
              !occupied(map_q, row_q, col_q - 4'd1) &&
              !occupied(map_q, row_q + 5'd1, col_q - 4'd1))
            col_d = col_q - 4'd1;
        end else if (move_right && !move_left) begin
          if (col_q < 4'd8 &&
              !occupied(map_q, row_q, col_q + 4'd2) &&
              !occupied(map_q, row_q + 5'd1, col_q + 4'd2))
            col_d = col_q + 4'd1;
        end
        // A due gravity step stays pending while move pulses keep arriving.
        grav_evt = (grav_q == GRAV_TOP || soft_drop) && !mv;
        if (grav_evt) begin
          grav_d = '0;
          if (row_q < 5'd18 &&
              !occupied(map_q, row_q + 5'd2, col_q) &&
              !occupied(map_q, row_q + 5'd2, col_q + 4'd1))
            row_d = row_q + 5'd1;
          else
            state_d = S_LOCK;
        end else if (grav_q != GRAV_TOP) begin
          grav_d = grav_q + GW'(1);
        end
      end
      S_LOCK: begin
        map_d[base]         = 1'b1;
        map_d[base + 8'd1]  = 1'b1;
        map_d[base + 8'd10] = 1'b1;
        map_d[base + 8'd11] = 1'b1;
        chk_d   = row_q + 5'd1;
        rem_d   = 2'd2;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        rem_d = rem_q - 2'd1;
        if (row_full(map_q, chk_q)) begin
          map_d = (map_q & keep_mask) | ((map_q << 10) & ~keep_mask);
          if (lines_q != '1) lines_d = lines_q + 1'b1;
        end else if (chk_q != 5'd0) begin
          chk_d = chk_q - 5'd1;
        end
        if (rem_q == 2'd1) state_d = S_SPAWN;
      end
      S_GAMEOVER: begin
        if (start) begin
          map_d   = '0;
          lines_d = '0;
          state_d = S_SPAWN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= 4'd4;
      map_q   <= '0;
      lines_q <= '0;
      grav_q  <= '0;
      chk_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      map_q   <= map_d;
      lines_q <= lines_d;
      grav_q  <= grav_d;
      chk_q   <= chk_d;
      rem_q   <= rem_d;
    end
  end

  assign piece_row   = row_q;
  assign piece_col   = col_q;
  assign piece_valid = (state_q == S_FALL);
  assign stack_map   = map_q;
  assign lines       = lines_q;
  assign busy        = (state_q == S_SPAWN) || (state_q == S_LOCK) ||
                       (state_q == S_CLEAR);
  assign game_over   = (state_q == S_GAMEOVER);

endmodule

// File: tb/tb_tetris_drop_ctrl.sv
// tb_tetris_drop_ctrl
//   Drives tetris_drop_ctrl with directed game scenarios and random pulses,
//   comparing every output each cycle against a playfield model kept as a
//   2-D cell array with integer piece coordinates.
module tb_tetris_drop_ctrl;

  localparam int DD = 4;
  localparam int LW = 8;

  localparam int MD_IDLE  = 0;
  localparam int MD_SPAWN = 1;
  localparam int MD_FALL  = 2;
  localparam int MD_LOCK  = 3;
  localparam int MD_CLEAR = 4;
  localparam int MD_OVER  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          move_left = 1'b0;
  logic          move_right = 1'b0;
  logic          soft_drop = 1'b0;
  logic [4:0]    piece_row;
  logic [3:0]    piece_col;
  logic          piece_valid;
  logic [199:0]  stack_map;
  logic [LW-1:0] lines;
  logic          busy;
  logic          game_over;

  int n_checks = 0;
  int n_fail   = 0;

  // playfield model
  bit grid[20][10];
  int m_mode, m_r, m_c, m_cnt, m_chk, m_rem, m_lines;

  always #5 clk = ~clk;

  tetris_drop_ctrl #(.DROP_DIV(DD), .LINES_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .move_left(move_left), .move_right(move_right), .soft_drop(soft_drop),
    .piece_row(piece_row), .piece_col(piece_col), .piece_valid(piece_valid),
    .stack_map(stack_map), .lines(lines), .busy(busy), .game_over(game_over)
  );

  task automatic check_eq(input string tag, input logic [199:0] got,
                          input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cell_free(input int y, input int x);
    if (y < 0 || y > 19 || x < 0 || x > 9) return 1'b0;
    return !grid[y][x];
  endfunction

  function automatic logic [199:0] model_map();
    logic [199:0] m;
    m = '0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++)
        m[y*10 + x] = grid[y][x];
    return m;
  endfunction

  task automatic clear_grid();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++)
        grid[y][x] = 1'b0;
  endtask

  task automatic model_step(input bit rs, input bit st, input bit l,
                            input bit r, input bit sd);
    bit full, grav;
    if (rs) begin
      m_mode = MD_IDLE; m_r = 0; m_c = 4; m_cnt = 0; m_chk = 0; m_rem = 0;
      m_lines = 0;
      clear_grid();
      return;
    end
    case (m_mode)
      MD_IDLE: if (st) m_mode = MD_SPAWN;
      MD_SPAWN: begin
        m_r = 0; m_c = 4; m_cnt = 0;
        if (grid[0][4] || grid[0][5] || grid[1][4] || grid[1][5]) m_mode = MD_OVER;
        else m_mode = MD_FALL;
      end
      MD_FALL: begin
        if (l && !r) begin
          if (m_c > 0 && cell_free(m_r, m_c-1) && cell_free(m_r+1, m_c-1)) m_c--;
        end else if (r && !l) begin
          if (m_c < 8 && cell_free(m_r, m_c+2) && cell_free(m_r+1, m_c+2)) m_c++;
        end
        grav = (m_cnt == DD-1 || sd) && !(l || r);
        if (grav) begin
          m_cnt = 0;
          if (m_r < 18 && cell_free(m_r+2, m_c) && cell_free(m_r+2, m_c+1)) m_r++;
          else m_mode = MD_LOCK;
        end else if (m_cnt < DD-1) begin
          m_cnt++;
        end
      end
      MD_LOCK: begin
        grid[m_r][m_c] = 1'b1;   grid[m_r][m_c+1] = 1'b1;
        grid[m_r+1][m_c] = 1'b1; grid[m_r+1][m_c+1] = 1'b1;
        m_chk = m_r + 1; m_rem = 2; m_mode = MD_CLEAR;
      end
      MD_CLEAR: begin
        full = 1'b1;
        for (int x = 0; x < 10; x++) full &= grid[m_chk][x];
        if (full) begin
          for (int y = m_chk; y >= 1; y--) grid[y] = grid[y-1];
          for (int x = 0; x < 10; x++) grid[0][x] = 1'b0;
          if (m_lines < (1 << LW) - 1) m_lines++;
        end else if (m_chk > 0) begin
          m_chk--;
        end
        m_rem--;
        if (m_rem == 0) m_mode = MD_SPAWN;
      end
      MD_OVER: if (st) begin
        clear_grid(); m_lines = 0; m_mode = MD_SPAWN;
      end
      default: m_mode = MD_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check_eq("piece_row", piece_row, m_r);
    check_eq("piece_col", piece_col, m_c);
    check_eq("piece_valid", piece_valid, m_mode == MD_FALL);
    check_eq("stack_map", stack_map, model_map());
    check_eq("lines", lines, m_lines);
    check_eq("busy", busy,
             m_mode == MD_SPAWN || m_mode == MD_LOCK || m_mode == MD_CLEAR);
    check_eq("game_over", game_over, m_mode == MD_OVER);
  endtask

  task automatic tick(input bit rs, input bit st, input bit l, input bit r,
                      input bit sd);
    rst = rs; start = st; move_left = l; move_right = r; soft_drop = sd;
    @(posedge clk);
    #1;
    model_step(rs, st, l, r, sd);
    compare_all();
    rst = 1'b0; start = 1'b0; move_left = 1'b0; move_right = 1'b0;
    soft_drop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0);
  endtask

  task automatic wait_mode(input int md, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_mode == md) break;
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 10; i++) begin
      if (!(m_mode == MD_SPAWN || m_mode == MD_LOCK || m_mode == MD_CLEAR)) break;
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic new_game();
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    wait_mode(MD_FALL, 5);
  endtask

  task automatic drop_at(input int col);
    wait_mode(MD_FALL, 10);
    for (int i = 0; i < 10 && m_c > col; i++) tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 10 && m_c < col; i++) tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 40 && m_mode == MD_FALL; i++) tick(0, 0, 0, 0, 1);
    settle();
  endtask

  logic [199:0] exp_map;
  int exp_col;

  initial begin
    // reset state and ignored inputs in IDLE
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check_eq("rst_col", piece_col, 4);
    check_eq("rst_map", stack_map, 0);
    tick(0, 0, 1, 0, 1);
    tick(0, 0, 0, 1, 0);

    // natural fall to the floor and lock
    tick(0, 1, 0, 0, 0);
    wait_mode(MD_FALL, 5);
    wait_mode(MD_LOCK, 100);
    wait_mode(MD_FALL, 10);
    exp_map = '0;
    exp_map[184] = 1'b1; exp_map[185] = 1'b1;
    exp_map[194] = 1'b1; exp_map[195] = 1'b1;
    check_eq("first_lock_map", stack_map, exp_map);
    check_eq("respawn_row", piece_row, 0);
    check_eq("respawn_lines", lines, 0);

    // left moves to the wall, then right moves to the far wall
    exp_col = 4;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 0, 0);
      if (exp_col > 0) exp_col--;
      check_eq("left_walk", piece_col, exp_col);
      tick(0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 9; i++) begin
      tick(0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 0);
    end
    check_eq("right_wall", piece_col, 8);

    // simultaneous left+right, including while gravity is due
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 1, 0);
    idle(2);
    tick(0, 0, 1, 1, 1);
    idle(3);

    // five pieces fill rows 18 and 19, two line clears
    new_game();
    drop_at(0); drop_at(2); drop_at(4); drop_at(6); drop_at(8);
    check_eq("clear_lines", lines, 2);
    check_eq("clear_map", stack_map, 0);

    // stack column 4 to the top, top-out, restart
    new_game();
    for (int k = 0; k < 10; k++) drop_at(4);
    check_eq("topout_over", game_over, 1);
    check_eq("topout_valid", piece_valid, 0);
    tick(0, 0, 1, 0, 1);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check_eq("restart_map", stack_map, 0);
    check_eq("restart_valid", piece_valid, 1);

    // reset mid-FALL
    idle(6);
    tick(1, 0, 0, 0, 0);
    check_eq("rstfall_busy", busy, 0);
    check_eq("rstfall_col", piece_col, 4);

    // reset mid-CLEAR
    new_game();
    for (int i = 0; i < 40 && m_mode != MD_CLEAR; i++) tick(0, 0, 0, 0, 1);
    check_eq("in_clear", busy, 1);
    tick(1, 0, 0, 0, 0);
    check_eq("rstclr_map", stack_map, 0);
    check_eq("rstclr_busy", busy, 0);
    check_eq("rstclr_over", game_over, 0);

    // random pulses
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
